// File: rtl/wisc_perf_counters.sv
// Event/cycle performance counters with a valid/ready dump on processor halt.
// Define PERF_SATURATE_EN for saturating counters; default build wraps.
module wisc_perf_counters #(
   parameter int NUM_EVT   = 8,
   parameter int CNT_WIDTH = 32,
   parameter int IDX_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic [NUM_EVT-1:0]   evt_inc,
   input  logic [NUM_EVT-1:0]   evt_en,
   input  logic                 halt,
   output logic                 dump_valid,
   input  logic                 dump_ready,
   output logic [IDX_WIDTH-1:0] dump_idx,
   output logic [CNT_WIDTH-1:0] dump_count,
   output logic                 dump_last,
   output logic [NUM_EVT:0]     ovf,
   output logic                 done
);

   localparam int NCH = NUM_EVT + 1;

   typedef enum logic [1:0] {
      S_COUNT,
      S_DUMP,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [CNT_WIDTH-1:0] r_cnt     [NCH];
   logic [CNT_WIDTH-1:0] w_cnt_nxt [NCH];
   logic [NUM_EVT:0]     r_ovf;
   logic [NUM_EVT:0]     w_ovf_nxt;
   logic [NUM_EVT:0]     w_inc;

   logic                 r_valid;
   logic                 w_valid_nxt;
   logic [IDX_WIDTH-1:0] r_idx;
   logic [IDX_WIDTH-1:0] w_idx_nxt;
   logic [IDX_WIDTH-1:0] w_idx_inc;
   logic [CNT_WIDTH-1:0] r_count;
   logic [CNT_WIDTH-1:0] w_count_nxt;
   logic [CNT_WIDTH-1:0] w_sel_cnt;
   logic                 r_last;
   logic                 w_last_nxt;
   logic                 r_done;
   logic                 w_done_nxt;

   logic                 w_xfer;
   logic                 w_halt_go;
   logic                 w_clr_ok;

   // Top bit is the cycle counter, which counts every edge
   assign w_inc     = {1'b1, evt_inc & evt_en};
   assign w_xfer    = r_valid && dump_ready;
   assign w_halt_go = (r_state == S_COUNT) && halt && !clear;
   assign w_clr_ok  = clear && (r_state != S_DUMP);
   assign w_idx_inc = r_idx + IDX_WIDTH'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_COUNT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_COUNT: begin
            if (w_halt_go) begin
               w_state_nxt = S_DUMP;
            end
         end
         S_DUMP: begin
            if (w_xfer && r_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (clear) begin
               w_state_nxt = S_COUNT;
            end
         end
         default: w_state_nxt = S_COUNT;
      endcase
   end

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         w_cnt_nxt[i] = r_cnt[i];
         w_ovf_nxt[i] = r_ovf[i];
         if (w_clr_ok) begin
            w_cnt_nxt[i] = '0;
            w_ovf_nxt[i] = 1'b0;
         end else if ((r_state == S_COUNT) && w_inc[i]) begin
            if (&r_cnt[i]) begin
               w_ovf_nxt[i] = 1'b1;
`ifdef PERF_SATURATE_EN
               w_cnt_nxt[i] = r_cnt[i];
`else
               w_cnt_nxt[i] = '0;
`endif
            end else begin
               w_cnt_nxt[i] = r_cnt[i] + CNT_WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NCH; i++) begin
            r_cnt[i] <= '0;
         end
         r_ovf <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            r_cnt[i] <= w_cnt_nxt[i];
         end
         r_ovf <= w_ovf_nxt;
      end
   end

   always_comb begin
      w_sel_cnt = '0;
      for (int i = 0; i < NCH; i++) begin
         if (w_idx_inc == IDX_WIDTH'(i)) begin
            w_sel_cnt = r_cnt[i];
         end
      end
   end

   // Next values of the registered dump outputs
   always_comb begin
      w_valid_nxt = r_valid;
      w_idx_nxt   = r_idx;
      w_count_nxt = r_count;
      w_last_nxt  = r_last;
      w_done_nxt  = r_done;
      unique case (r_state)
         S_COUNT: begin
            if (w_halt_go) begin
               w_valid_nxt = 1'b1;
               w_idx_nxt   = '0;
               w_count_nxt = w_cnt_nxt[0];
               w_last_nxt  = 1'b0;
               w_done_nxt  = 1'b0;
            end
         end
         S_DUMP: begin
            if (w_xfer) begin
               if (r_last) begin
                  w_valid_nxt = 1'b0;
                  w_idx_nxt   = '0;
                  w_count_nxt = '0;
                  w_last_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_idx_nxt   = w_idx_inc;
                  w_count_nxt = w_sel_cnt;
                  w_last_nxt  = (w_idx_inc == IDX_WIDTH'(NUM_EVT));
               end
            end
         end
         S_DONE: begin
            if (clear) begin
               w_done_nxt = 1'b0;
            end
         end
         default: begin
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= 1'b0;
         r_idx   <= '0;
         r_count <= '0;
         r_last  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_valid <= w_valid_nxt;
         r_idx   <= w_idx_nxt;
         r_count <= w_count_nxt;
         r_last  <= w_last_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign dump_valid = r_valid;
   assign dump_idx   = r_idx;
   assign dump_count = r_count;
   assign dump_last  = r_last;
   assign ovf        = r_ovf;
   assign done       = r_done;

endmodule

// File: tb/tb_wisc_perf_counters.sv
// Directed bench for wisc_perf_counters: scoreboard of expected dump words.
// A second 4-bit instance covers counter overflow.
module tb_wisc_perf_counters;

   localparam int N  = 8;
   localparam int W  = 32;
   localparam int IW = 4;
   localparam int W4 = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          clear;
   logic          halt;
   logic          dump_ready;
   logic [N-1:0]  evt_inc;
   logic [N-1:0]  evt_en;
   logic          dump_valid;
   logic [IW-1:0] dump_idx;
   logic [W-1:0]  dump_count;
   logic          dump_last;
   logic [N:0]    ovf;
   logic          done;

   logic          clear4;
   logic          halt4;
   logic          ready4;
   logic [N-1:0]  evt_inc4;
   logic          valid4;
   logic [IW-1:0] idx4;
   logic [W4-1:0] count4;
   logic          last4;
   logic [N:0]    ovf4;
   logic          done4;

   always #5 clk = ~clk;

   wisc_perf_counters #(.NUM_EVT(N), .CNT_WIDTH(W), .IDX_WIDTH(IW)) u_dut (
      .clk(clk), .rst(rst), .clear(clear),
      .evt_inc(evt_inc), .evt_en(evt_en), .halt(halt),
      .dump_valid(dump_valid), .dump_ready(dump_ready),
      .dump_idx(dump_idx), .dump_count(dump_count),
      .dump_last(dump_last), .ovf(ovf), .done(done)
   );

   wisc_perf_counters #(.NUM_EVT(N), .CNT_WIDTH(W4), .IDX_WIDTH(IW)) u_dut4 (
      .clk(clk), .rst(rst), .clear(clear4),
      .evt_inc(evt_inc4), .evt_en({N{1'b1}}), .halt(halt4),
      .dump_valid(valid4), .dump_ready(ready4),
      .dump_idx(idx4), .dump_count(count4),
      .dump_last(last4), .ovf(ovf4), .done(done4)
   );

   typedef struct packed {
      logic [IW-1:0] idx;
      logic [W-1:0]  cnt;
      logic          last;
   } word_t;

   word_t        sbq[$];
   logic [W-1:0] m_cnt [N+1];
   int           m_st;
   int           checks = 0;
   int           errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i <= N; i++) m_cnt[i] = '0;
   endtask

   // Called at a negedge with inputs already driven; returns at next negedge
   task automatic tick();
      word_t w;
      logic  xl;
      xl = 1'b0;
      chk("valid", dump_valid, (m_st == 1));
      chk("done", done, (m_st == 2));
      if (dump_valid && dump_ready) begin
         chk("sb_nonempty", (sbq.size() > 0), 1);
         if (sbq.size() > 0) begin
            w = sbq.pop_front();
            chk("dump_idx", dump_idx, w.idx);
            chk("dump_count", dump_count, w.cnt);
            chk("dump_last", dump_last, w.last);
            xl = w.last;
         end
      end
      @(posedge clk);
      case (m_st)
         0: begin
            if (clear) begin
               model_clear();
            end else begin
               for (int i = 0; i < N; i++)
                  if (evt_inc[i] && evt_en[i]) m_cnt[i] = m_cnt[i] + 1;
               m_cnt[N] = m_cnt[N] + 1;
               if (halt) begin
                  m_st = 1;
                  for (int i = 0; i <= N; i++) begin
                     w.idx  = IW'(i);
                     w.cnt  = m_cnt[i];
                     w.last = (i == N);
                     sbq.push_back(w);
                  end
               end
            end
         end
         1: if (xl) m_st = 2;
         2: begin
            if (clear) begin
               model_clear();
               m_st = 0;
            end
         end
         default: m_st = 0;
      endcase
      @(negedge clk);
   endtask

   task automatic run_dump(input int hold_idx, input int clr_idx);
      int hold;
      hold = 0;
      for (int c = 0; c < 60 && m_st == 1; c++) begin
         dump_ready = 1'b1;
         clear      = 1'b0;
         halt       = 1'b1;
         if (dump_idx == IW'(hold_idx) && hold < 3) begin
            dump_ready = 1'b0;
            hold++;
            chk("hold_idx", dump_idx, hold_idx);
            chk("hold_count", dump_count, m_cnt[hold_idx]);
            chk("hold_last", dump_last, 0);
         end
         if (dump_idx == IW'(clr_idx)) clear = 1'b1;
         tick();
      end
      dump_ready = 1'b1;
      clear      = 1'b0;
      halt       = 1'b0;
      chk("dump_finished", m_st, 2);
      chk("sb_drained", sbq.size(), 0);
   endtask

   initial begin
      rst        = 1'b0;
      clear      = 1'b0;
      halt       = 1'b0;
      dump_ready = 1'b1;
      evt_inc    = '0;
      evt_en     = '1;
      clear4     = 1'b0;
      halt4      = 1'b0;
      ready4     = 1'b1;
      evt_inc4   = '0;
      model_clear();
      m_st = 0;

      repeat (3) @(negedge clk);
      chk("rst_valid", dump_valid, 0);
      chk("rst_idx", dump_idx, 0);
      chk("rst_count", dump_count, 0);
      chk("rst_last", dump_last, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_done", done, 0);
      rst = 1'b1;

      // Channels 0/4 count, channel 2 masked; back-pressure at idx 4
      evt_en  = 8'hFB;
      evt_inc = 8'h15;
      repeat (10) tick();
      halt = 1'b1;
      tick();
      halt    = 1'b0;
      evt_inc = '0;
      evt_en  = '1;
      run_dump(4, 2);
      chk("a_ovf", ovf, 0);
      chk("a_done", done, 1);

      // DONE holds and ignores halt; clear returns to COUNT
      evt_inc = '1;
      halt    = 1'b1;
      repeat (2) tick();
      halt    = 1'b0;
      evt_inc = '0;
      clear   = 1'b1;
      tick();
      clear   = 1'b0;
      chk("b_done_low", done, 0);
      evt_inc = 8'h01;
      repeat (3) tick();
      clear = 1'b1;
      tick();
      clear   = 1'b0;
      evt_inc = 8'h02;
      repeat (2) tick();
      evt_inc = '0;
      halt    = 1'b1;
      tick();
      halt = 1'b0;
      run_dump(-1, -1);

      // Asynchronous reset in the middle of a dump
      clear = 1'b1;
      tick();
      clear   = 1'b0;
      evt_inc = 8'h81;
      repeat (4) tick();
      evt_inc = '0;
      halt    = 1'b1;
      tick();
      halt = 1'b0;
      for (int c = 0; c < 20 && !(dump_valid && dump_idx == IW'(3)); c++)
         tick();
      chk("c_at_idx3", dump_idx, 3);
      #2 rst = 1'b0;
      #1;
      chk("c_rst_valid", dump_valid, 0);
      chk("c_rst_idx", dump_idx, 0);
      chk("c_rst_count", dump_count, 0);
      chk("c_rst_last", dump_last, 0);
      chk("c_rst_ovf", ovf, 0);
      chk("c_rst_done", done, 0);
      sbq.delete();
      model_clear();
      m_st = 0;
      @(negedge clk);
      rst     = 1'b1;
      evt_inc = 8'h01;
      repeat (2) tick();
      halt = 1'b1;
      tick();
      halt    = 1'b0;
      evt_inc = '0;
      run_dump(-1, -1);

      // 4-bit counters: 20 increments on channel 1
      evt_inc4 = 8'h02;
      repeat (20) tick();
      evt_inc4 = '0;
      halt4    = 1'b1;
      tick();
      halt4 = 1'b0;
      chk("d_ovf", ovf4, 9'h102);
      for (int c = 0; c < 5 && !(valid4 && idx4 == IW'(1)); c++) tick();
      chk("d_valid", valid4, 1);
      chk("d_idx", idx4, 1);
`ifdef PERF_SATURATE_EN
      chk("d_count", count4, 15);
`else
      chk("d_count", count4, 4);
`endif
      chk("d_last", last4, 0);
      chk("d_done", done4, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wisc_perf_counters.md
WISC_PERF_COUNTERS -- requirements
Module: wisc_perf_counters

Interface
REQ-001 SHALL have parameter NUM_EVT, default 8, giving the number of event channels (1..16).
REQ-002 SHALL have parameter CNT_WIDTH, default 32, giving the width of each counter (4..32).
REQ-003 SHALL have parameter IDX_WIDTH, default 4, giving the dump index width; it SHALL hold NUM_EVT (channel NUM_EVT carries the cycle count).
REQ-004 clk  input  1  single clock, rising-edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low; low = reset.
REQ-006 clear  input  1  synchronous zeroing of all counters and overflow flags.
REQ-007 evt_inc  input  NUM_EVT  per-channel event strobe; +1 per cycle while high (e.g. RegWrite, icache_req, icache_hit, dcache_req, dcache_hit).
REQ-008 evt_en  input  NUM_EVT  per-channel count enable mask.
REQ-009 halt  input  1  processor halt from WriteBack; starts the dump.
REQ-010 dump_valid  output  1  dump word valid.
REQ-011 dump_ready  input  1  consumer accepts the dump word.
REQ-012 dump_idx  output  IDX_WIDTH  channel index of the dump word.
REQ-013 dump_count  output  CNT_WIDTH  counter value of the dump word.
REQ-014 dump_last  output  1  high with the final dump word.
REQ-015 ovf  output  NUM_EVT+1  sticky per-channel overflow flag; bit NUM_EVT = cycle counter.
REQ-016 done  output  1  high in state DONE.

Function
REQ-017 SHALL implement states COUNT, DUMP and DONE, entering COUNT out of reset.
REQ-018 In COUNT, channel i SHALL add 1 on each rising edge with evt_inc[i] && evt_en[i]; the cycle counter SHALL add 1 on every rising edge.
REQ-019 In COUNT, clear SHALL zero all counters and ovf at the next edge and override that cycle's increments.
REQ-020 In COUNT, halt SHALL count that cycle's events and cycle, and move to DUMP at the same edge, with dump_idx = 0.
REQ-021 In DUMP, dump_valid SHALL be 1 and dump_count SHALL be the frozen value of channel dump_idx; no counter SHALL change.
REQ-022 A word SHALL transfer on an edge with dump_valid && dump_ready; dump_idx SHALL then increment by 1.
REQ-023 dump_idx, dump_count and dump_last SHALL remain stable while dump_valid && !dump_ready.
REQ-024 dump_last SHALL be 1 only when dump_idx == NUM_EVT; its transfer SHALL move the block to DONE.
REQ-025 In DONE, dump_valid SHALL be 0, done SHALL be 1, and counters SHALL hold; clear SHALL zero the counters and return the block to COUNT.
REQ-026 halt SHALL be ignored in DUMP and DONE; clear SHALL be ignored in DUMP.
REQ-027 Counters SHALL be unsigned CNT_WIDTH-bit; overflow behaviour per REQ-031/REQ-032.
REQ-028 Outputs SHALL be registered, with no combinational path from dump_ready to dump_valid.

Reset
REQ-029 rst low SHALL asynchronously force state COUNT, all counters 0, ovf 0, dump_valid 0, dump_idx 0, dump_count 0, dump_last 0 and done 0, including in the middle of a dump.
REQ-030 The first counting edge SHALL be the first rising clk edge after rst is sampled high.

Configuration
REQ-031 With macro PERF_SATURATE_EN defined, a counter at all-ones SHALL hold all-ones on further increments and set its ovf bit.
REQ-032 Without PERF_SATURATE_EN, a counter SHALL wrap from all-ones to 0 and set its sticky ovf bit.

Verification
REQ-033 Defaults: reset, 10 cycles with evt_inc[0]=1 and evt_en=all-ones, then halt -> 9 words with channel 0 = 11, others 0, channel 8 = 11, dump_last only on idx 8, then done=1.
REQ-034 evt_en[2]=0 with evt_inc[2]=1 for 5 cycles -> channel 2 dumps 0.
REQ-035 dump_ready=0 for 3 cycles on idx 4 -> idx/count/last held; then dump continues at idx 5 with no words lost or duplicated.
REQ-036 CNT_WIDTH=4, 20 increments on channel 1 -> 15 with ovf[1]=1 under PERF_SATURATE_EN; 4 with ovf[1]=1 without it.
REQ-037 clear and evt_inc[0] in the same COUNT cycle -> channel 0 = 0; clear during DUMP is ignored; clear in DONE -> COUNT, all counters 0.
REQ-038 rst low mid-DUMP at idx 3 -> all outputs 0 immediately with no clock edge needed; after release the block is in COUNT from 0.
